// File: rtl/if_id_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_id_stage_pkg
// Shared definitions for the RV32I fetch stage and its helpers:
//   - RV32I major opcode constants (inst[6:0])
//   - canonical NOP encoding (addi x0, x0, 0) used for IF/ID bubbles
//   - default reset PC
//   - saturating 32-bit increment used by the optional event counters
// ---------------------------------------------------------------------------
package if_id_stage_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_stage_src_use_decode.sv
// ---------------------------------------------------------------------------
// src_use_decode
// Combinational source-operand use decode for an RV32I instruction slot.
// Tells the hazard logic whether the instruction actually reads rs1 / rs2,
// so that immediate bits that happen to alias a register index do not cause
// false stalls. An invalid slot (bubble) never reads anything.
//
// Ports:
//   opcode_i     [6:0]  inst[6:0] of the slot
//   valid_i             slot holds a real instruction
//   detect_r1_o         instruction reads rs1
//   detect_r2_o         instruction reads rs2
// ---------------------------------------------------------------------------
module src_use_decode
  import if_id_stage_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic       valid_i,
  output logic       detect_r1_o,
  output logic       detect_r2_o
);

  logic uses_r1;
  logic uses_r2;

  always_comb begin
    uses_r1 = 1'b0;
    uses_r2 = 1'b0;
    case (opcode_i)
      OP_R, OP_STORE, OP_BRANCH: begin
        uses_r1 = 1'b1;
        uses_r2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        uses_r1 = 1'b1;
      end
      // lui, auipc, jal and unknown opcodes read no registers
      default: begin
        uses_r1 = 1'b0;
        uses_r2 = 1'b0;
      end
    endcase
  end

  assign detect_r1_o = uses_r1 & valid_i;
  assign detect_r2_o = uses_r2 & valid_i;

endmodule

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
// Instruction-fetch stage of a 5-stage RV32I pipeline: PC register, IROM
// word-address generation and the IF/ID pipeline register. Feeds the data
// hazard detector with rs1/rs2 and their use qualifiers, and takes back its
// suspend request plus the EXE-stage branch redirect.
//
// Per-edge priority: rst_i > branch_taken_i > suspend_i > advance.
//
// Parameters:
//   RESET_PC   PC loaded on reset
//   IROM_AW    IROM word-address width (irom_addr_o = pc[IROM_AW+1:2])
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   suspend_i             stall request from the hazard detector
//   branch_taken_i        EXE-stage redirect
//   branch_target_i       redirect target (low two bits ignored)
//   inst_i                combinational IROM read data for irom_addr_o
//   irom_addr_o           IROM word address
//   pc_o                  current fetch PC
//   if_id_pc_o/pc4_o      PC (and PC+4) of the ID instruction
//   if_id_inst_o          ID instruction
//   if_id_valid_o         ID slot holds a real instruction
//   if_id_rs1/rs2/rd_o    register fields of the ID instruction
//   detect_r1_o/r2_o      ID instruction reads rs1 / rs2
//   id_exe_flush_o        load a bubble into ID/EX this cycle
//
// Optional build macro IF_STALL_CNT_EN adds saturating event counters:
//   stall_cnt_o           edges with suspend_i=1 and branch_taken_i=0
//   flush_cnt_o           edges with branch_taken_i=1
// ---------------------------------------------------------------------------
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IROM_AW  = 14
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               suspend_i,
  input  logic               branch_taken_i,
  input  logic [31:0]        branch_target_i,
  input  logic [31:0]        inst_i,
  output logic [IROM_AW-1:0] irom_addr_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        if_id_pc_o,
  output logic [31:0]        if_id_pc4_o,
  output logic [31:0]        if_id_inst_o,
  output logic               if_id_valid_o,
  output logic [4:0]         if_id_rs1_o,
  output logic [4:0]         if_id_rs2_o,
  output logic [4:0]         if_id_rd_o,
  output logic               detect_r1_o,
  output logic               detect_r2_o,
  output logic               id_exe_flush_o
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o
`endif
);

  logic [31:0] pc_q,    pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] pc_plus4;

  // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (branch_taken_i) begin
      // Redirect beats a simultaneous suspend: the stalled ID instruction
      // is on the wrong path, so it is replaced by a bubble.
      pc_d       = branch_target_i & 32'hFFFF_FFFC;
      id_pc_d    = 32'd0;
      id_pc4_d   = 32'd0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (!suspend_i) begin
      pc_d       = pc_plus4;
      id_pc_d    = pc_q;
      id_pc4_d   = pc_plus4;
      id_inst_d  = inst_i;
      id_valid_d = 1'b1;
    end
    // suspend without redirect: everything holds so rs1/rs2 stay stable
  end

  // PC and IF/ID register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'd0;
      id_pc4_q   <= 32'd0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign irom_addr_o   = pc_q[IROM_AW+1:2];
  assign pc_o          = pc_q;
  assign if_id_pc_o    = id_pc_q;
  assign if_id_pc4_o   = id_pc4_q;
  assign if_id_inst_o  = id_inst_q;
  assign if_id_valid_o = id_valid_q;

  // Bubbles carry NOP (addi x0,x0,0), so the register fields read as zero.
  assign if_id_rs1_o = id_inst_q[19:15];
  assign if_id_rs2_o = id_inst_q[24:20];
  assign if_id_rd_o  = id_inst_q[11:7];

  // Both a stall and a redirect send a bubble down into EXE.
  assign id_exe_flush_o = branch_taken_i | suspend_i;

  src_use_decode u_src_use_decode (
    .opcode_i    (id_inst_q[6:0]),
    .valid_i     (id_valid_q),
    .detect_r1_o (detect_r1_o),
    .detect_r2_o (detect_r2_o)
  );

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (branch_taken_i) begin
      flush_cnt_d = sat_inc32(flush_cnt_q);
    end else if (suspend_i) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end
  end

  // Event counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline: PC register, IROM address generation and the IF/ID pipeline register.
- Directly upstream of the data hazard detector. Supplies the ID-stage rs1/rs2 indices and the detect_r1/detect_r2 source-use qualifiers.
- Consumes the detector's suspend signal and the EXE-stage branch redirect.
- Emits the bubble request for the ID/EX register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IROM_AW, 14, IROM word-address width; irom_addr_o = pc[IROM_AW+1:2].

Ports:
- clk_i  input  1  pipeline clock
- rst_i  input  1  synchronous active-high reset
- suspend_i  input  1  stall request from data_hazard_detect.suspend_o
- branch_taken_i  input  1  EXE-stage redirect (taken branch, jal or jalr)
- branch_target_i  input  32  redirect target
- inst_i  input  32  IROM read data for irom_addr_o (combinational IROM)
- irom_addr_o  output  IROM_AW  IROM word address
- pc_o  output  32  current fetch PC
- if_id_pc_o  output  32  PC of the instruction in ID
- if_id_pc4_o  output  32  that PC + 4
- if_id_inst_o  output  32  instruction in ID
- if_id_valid_o  output  1  ID slot holds a real instruction
- if_id_rs1_o  output  5  inst[19:15] of the ID instruction
- if_id_rs2_o  output  5  inst[24:20] of the ID instruction
- if_id_rd_o  output  5  inst[11:7] of the ID instruction
- detect_r1_o  output  1  ID instruction reads rs1
- detect_r2_o  output  1  ID instruction reads rs2
- id_exe_flush_o  output  1  load a bubble into ID/EX this cycle

Behaviour:
- Clocking: one clock, clk_i. Reset is synchronous and active-high on rst_i. All registers update on the rising edge.
- Reset values:
  - pc = RESET_PC.
  - if_id_pc = 0, if_id_pc4 = 0.
  - if_id_inst = NOP (32'h0000_0013).
  - if_id_valid = 0.
  - Derived outputs therefore reset to rs1 = 0, rs2 = 0, rd = 0, detect_r1 = 0, detect_r2 = 0.
- Per-edge priority is rst_i > branch_taken_i > suspend_i > advance.
  - Redirect:
    - pc <= {branch_target_i[31:2], 2'b00}.
    - IF/ID <= bubble: inst = NOP, valid = 0, pc and pc4 = 0.
    - Redirect wins over a simultaneous suspend_i; the stalled ID instruction is wrong-path and is discarded.
  - Suspend (no redirect):
    - pc holds.
    - Every IF/ID field holds, so rs1/rs2 stay stable for the detector.
  - Advance:
    - pc <= pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
    - IF/ID <= {pc, pc + 4, inst_i, valid = 1}.
- Fetch latency: one cycle, from pc_o to the instruction appearing on if_id_inst_o.
- irom_addr_o is combinational from the pc register.
- id_exe_flush_o = branch_taken_i | suspend_i, combinational.
  - Suspend: the ID instruction is held and a bubble goes down the pipe.
  - Redirect: the wrong-path ID instruction is killed.
- rs1/rs2/rd are pure bit slices of if_id_inst. A bubble gives 0, 0, 0.
- detect_r1/detect_r2 decode the opcode in if_id_inst[6:0], ANDed with if_id_valid:
  - 0110011 (R), 0100011 (S), 1100011 (B): rs1 = 1, rs2 = 1.
  - 0010011 (I-arith), 0000011 (load), 1100111 (jalr): rs1 = 1, rs2 = 0.
  - 0110111 (lui), 0010111 (auipc), 1101111 (jal), any other opcode: rs1 = 0, rs2 = 0.
- Suspend lasting N cycles: pc and IF/ID are frozen for exactly N edges. Advance resumes on the first edge with suspend_i = 0.
- Reset mid-stall or mid-redirect: reset wins outright; no state survives.

Optional Feature:
- Macro: IF_STALL_CNT_EN.
- Defined:
  - Adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments on each edge where suspend_i = 1 and branch_taken_i = 0.
  - flush_cnt_o increments on each edge where branch_taken_i = 1.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: neither port nor either counter exists. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - RV32I opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - NOP_INST = 32'h0000_0013.
  - Default RESET_PC.
- One sub-module, src_use_decode: a combinational map from {opcode, valid} to {detect_r1, detect_r2}. Reusable by the ID/EX stage.

Test Plan:
- Reset, then 4 free-running cycles with inst_i = 32'h00A00093 (addi x1,x0,10) → pc_o = 0, 4, 8, 12, 16. After the first edge, if_id_pc = 0, if_id_pc4 = 4, valid = 1, rs1 = 0, detect_r1 = 1, detect_r2 = 0.
- suspend_i high for 2 cycles at pc = 8 → pc_o stays 8 for 2 edges. if_id_inst, rs1 and rs2 are unchanged throughout. id_exe_flush_o = 1 both cycles. pc = 12 on the next edge.
- branch_taken_i = 1, branch_target_i = 32'h0000_0103 → next pc_o = 32'h100, if_id_inst = 32'h13, valid = 0, detect_r1 = 0, detect_r2 = 0.
- branch_taken_i and suspend_i asserted together at pc = 20, target 32'h40 → pc = 32'h40 and a bubble is loaded (redirect wins).
- Opcode sweep with ID instructions add (33), sw (23), lui (37), jal (6F), an illegal 7F opcode, and a bubble → detect pairs (1,1), (1,1), (0,0), (0,0), (0,0), (0,0).
- Force pc = 32'hFFFF_FFFC, advance once → pc_o = 0 and if_id_pc4 = 0. Assert rst_i during an active suspend → pc = RESET_PC and valid = 0 on that edge.
